// File: rtl/pc_reg_pkg.sv
// Shared types and constants for the unified register/instruction byte store.
package pc_reg_pkg;
   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   localparam int WORD_W   = 32;
   localparam int X0_LIMIT = 4;

   // A 4-byte access at addr fits entirely inside a store of mem_bytes bytes.
   function automatic logic in_range(input logic [WORD_W-1:0] addr, input int mem_bytes);
      return ({1'b0, addr} + 33'd3) < 33'(mem_bytes);
   endfunction
endpackage

// File: rtl/pc_reg_rdport.sv
// Combinational big-endian word read with range check, x0 masking and
// same-cycle bypass of the accepted store.
module pc_reg_rdport
   import pc_reg_pkg::*;
#(
   parameter int MEM_BYTES = 512
) (
   input  logic              en,
   input  logic [7:0]        mem [MEM_BYTES],
   input  logic [WORD_W-1:0] addr,
   input  logic              byp_en,
   input  logic [WORD_W-1:0] byp_addr,
   input  logic [WORD_W-1:0] byp_value,
   output logic [WORD_W-1:0] value,
   output logic              oor
);
   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0] bytes [4];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte
         logic [AW-1:0] idx;
         assign idx = addr[AW-1:0] + AW'(gi);
         // Bytes below X0_LIMIT read as zero even inside an unaligned word.
         assign bytes[gi] = (addr < WORD_W'(X0_LIMIT - gi)) ? 8'h00 : mem[idx];
      end
   endgenerate

   always_comb begin
      value = '0;
      oor   = !in_range(addr, MEM_BYTES);
      if (en && !oor) begin
         if (byp_en && (byp_addr == addr))
            value = byp_value;
         else
            value = {bytes[0], bytes[1], bytes[2], bytes[3]};
      end
   end
endmodule

// File: rtl/pc_reg_mem.sv
// Byte-addressed register/instruction store: clear sweep after reset, two
// combinational read ports, one write-back port and an instruction preload port.
module pc_reg_mem
   import pc_reg_pkg::*;
#(
   parameter int MEM_BYTES   = 512,
   parameter int CLR_PER_CYC = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] load_pc_reg_addr1,
   input  logic [WORD_W-1:0] load_pc_reg_addr2,
   output logic [WORD_W-1:0] load_pc_reg_value1,
   output logic [WORD_W-1:0] load_pc_reg_value2,
   input  logic              write_en,
   input  logic [WORD_W-1:0] write_pc_reg_addr,
   input  logic [WORD_W-1:0] write_pc_reg_value,
   input  logic              pre_en,
   input  logic [WORD_W-1:0] pre_addr,
   input  logic [WORD_W-1:0] pre_data,
   output logic              ready,
   output logic              addr_err
);
   localparam int AW = $clog2(MEM_BYTES);

   logic [7:0]        mem [MEM_BYTES];
   state_t            state_reg, state_next;
   logic [AW-1:0]     ptr_reg, ptr_next;
   logic              err_reg, err_next;
   logic              st_en, st_oor;
   logic [WORD_W-1:0] st_addr, st_value;
   logic [WORD_W-1:0] rd_addr  [2];
   logic [WORD_W-1:0] rd_value [2];
   logic              rd_oor   [2];

   assign ready    = (state_reg == RUN);
   assign addr_err = err_reg;

   // Write-back has priority; preload only uses the store when write-back is idle.
   always_comb begin
      st_addr  = write_en ? write_pc_reg_addr  : pre_addr;
      st_value = write_en ? write_pc_reg_value : pre_data;
      st_oor   = (write_en || pre_en) && !in_range(st_addr, MEM_BYTES);
      st_en    = ready && (write_en || pre_en) && !st_oor
                 && (st_addr >= WORD_W'(X0_LIMIT));
   end

   assign rd_addr[0]         = load_pc_reg_addr1;
   assign rd_addr[1]         = load_pc_reg_addr2;
   assign load_pc_reg_value1 = rd_value[0];
   assign load_pc_reg_value2 = rd_value[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         pc_reg_rdport #(.MEM_BYTES(MEM_BYTES)) u_rd (
            .en        (ready),
            .mem       (mem),
            .addr      (rd_addr[gi]),
            .byp_en    (st_en),
            .byp_addr  (st_addr),
            .byp_value (st_value),
            .value     (rd_value[gi]),
            .oor       (rd_oor[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      err_next   = err_reg;
      case (state_reg)
         CLEAR: begin
            ptr_next = ptr_reg + AW'(CLR_PER_CYC);
            if (ptr_reg == AW'(MEM_BYTES - CLR_PER_CYC)) begin
               ptr_next   = '0;
               state_next = RUN;
            end
         end
         RUN:     err_next = err_reg | rd_oor[0] | rd_oor[1] | st_oor;
         default: state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= CLEAR;
         ptr_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         err_reg   <= err_next;
      end
   end

   // Storage itself is not reset; the CLEAR sweep zeroes it instead.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_reg == CLEAR) begin
            for (int i = 0; i < CLR_PER_CYC; i++)
               mem[ptr_reg + AW'(i)] <= 8'h00;
         end else if (st_en) begin
            for (int i = 0; i < 4; i++)
               mem[st_addr[AW-1:0] + AW'(i)] <= st_value[31-8*i -: 8];
         end
      end
   end
endmodule

// File: tb/tb_pc_reg_mem.sv
// Directed plus randomized check of pc_reg_mem against a byte-array reference model.
module tb_pc_reg_mem;
   localparam int MB      = 512;
   localparam int CLR_CYC = 128;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] load_pc_reg_addr1, load_pc_reg_addr2;
   logic [31:0] load_pc_reg_value1, load_pc_reg_value2;
   logic        write_en, pre_en;
   logic [31:0] write_pc_reg_addr, write_pc_reg_value, pre_addr, pre_data;
   logic        ready, addr_err;

   always #5 clk = ~clk;

   pc_reg_mem #(.MEM_BYTES(MB), .CLR_PER_CYC(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .load_pc_reg_addr1  (load_pc_reg_addr1),
      .load_pc_reg_addr2  (load_pc_reg_addr2),
      .load_pc_reg_value1 (load_pc_reg_value1),
      .load_pc_reg_value2 (load_pc_reg_value2),
      .write_en           (write_en),
      .write_pc_reg_addr  (write_pc_reg_addr),
      .write_pc_reg_value (write_pc_reg_value),
      .pre_en             (pre_en),
      .pre_addr           (pre_addr),
      .pre_data           (pre_data),
      .ready              (ready),
      .addr_err           (addr_err)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  ref_mem [MB];
   bit          ref_err;
   int          clr_cnt;
   logic [31:0] v1, v2;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return ({32'd0, a} + 64'd3) < 64'(MB);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input bit se,
                                            input logic [31:0] sa, input logic [31:0] sv);
      logic [31:0] w;
      w = '0;
      if (clr_cnt < CLR_CYC || !in_rng(a)) return '0;
      if (se && a == sa) return sv;
      for (int k = 0; k < 4; k++)
         w = {w[23:0], ((a + k) < 4) ? 8'h00 : ref_mem[a + k]};
      return w;
   endfunction

   // One clock: drive, check reads/ready before the edge, update model, check addr_err after.
   task automatic step(input bit rst, input bit we, input logic [31:0] wa, input logic [31:0] wv,
                       input bit pe, input logic [31:0] pa, input logic [31:0] pd,
                       input logic [31:0] ra1, input logic [31:0] ra2);
      bit          rdy, se, soor;
      logic [31:0] sa, sv;
      reset = rst; write_en = we; write_pc_reg_addr = wa; write_pc_reg_value = wv;
      pre_en = pe; pre_addr = pa; pre_data = pd;
      load_pc_reg_addr1 = ra1; load_pc_reg_addr2 = ra2;
      #2;
      rdy  = (clr_cnt >= CLR_CYC);
      sa   = we ? wa : pa;
      sv   = we ? wv : pd;
      se   = 1'b0;
      soor = 1'b0;
      if (rdy && (we || pe)) begin
         if (!in_rng(sa)) soor = 1'b1;
         else if (sa >= 4) se = 1'b1;
      end
      v1 = load_pc_reg_value1;
      v2 = load_pc_reg_value2;
      check_eq("rd1", v1, ref_read(ra1, se, sa, sv));
      check_eq("rd2", v2, ref_read(ra2, se, sa, sv));
      check_eq("ready", 32'(ready), 32'(rdy));
      @(posedge clk);
      if (rst) begin
         clr_cnt = 0;
         ref_err = 1'b0;
      end else if (rdy) begin
         if (se)
            for (int k = 0; k < 4; k++) ref_mem[sa + k] = sv[31-8*k -: 8];
         if (soor || !in_rng(ra1) || !in_rng(ra2)) ref_err = 1'b1;
      end else begin
         clr_cnt++;
         if (clr_cnt == CLR_CYC)
            foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      end
      #1;
      check_eq("addr_err", 32'(addr_err), 32'(ref_err));
      @(negedge clk);
   endtask

   task automatic idle(input logic [31:0] ra1, input logic [31:0] ra2);
      step(1'b0, 1'b0, 0, 0, 1'b0, 0, 0, ra1, ra2);
   endtask

   task automatic wait_ready();
      int cnt;
      cnt = 0;
      while (!ready && cnt < 200) begin
         idle(20, 0);
         cnt++;
      end
      check_eq("clear_len", cnt, CLR_CYC);
   endtask

   function automatic logic [31:0] rnd_addr(input bit allow_oor);
      if (allow_oor && $urandom_range(0, 15) == 0) return $urandom_range(509, 520);
      if ($urandom_range(0, 7) == 0) return $urandom_range(480, 508);
      return $urandom_range(0, 40);
   endfunction

   initial begin
      reset = 1'b1; write_en = 1'b0; pre_en = 1'b0;
      write_pc_reg_addr = '0; write_pc_reg_value = '0;
      pre_addr = '0; pre_data = '0;
      load_pc_reg_addr1 = 20; load_pc_reg_addr2 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr_cnt = 0;
      ref_err = 1'b0;
      check_eq("rst_ready", 32'(ready), 0);
      check_eq("rst_err", 32'(addr_err), 0);
      check_eq("rst_val1", load_pc_reg_value1, 0);

      // Reset pulsed 50 cycles into the sweep restarts it.
      for (int i = 0; i < 50; i++) idle(20, 0);
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 20, 0);
      wait_ready();
      idle(20, 20);
      check_eq("rd20_zero", v1, 0);

      step(1'b0, 1'b0, 0, 0, 1'b1, 400, 32'h0070_0613, 0, 0);
      idle(400, 403);
      check_eq("pre400", v1, 32'h0070_0613);
      check_eq("pre403", v2, 32'h1300_0000);
      idle(401, 402);
      check_eq("pre401", v1, 32'h7006_1300);
      check_eq("pre402", v2, 32'h0613_0000);

      step(1'b0, 1'b1, 12, 15, 1'b0, 0, 0, 12, 16);
      check_eq("byp12", v1, 15);
      idle(12, 0);
      check_eq("rd12", v1, 15);

      step(1'b0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 0, 0, 0, 4);
      check_eq("x0_byp", v1, 0);
      idle(0, 1);
      check_eq("x0_rd", v1, 0);
      check_eq("x0_err", 32'(addr_err), 0);

      step(1'b0, 1'b1, 20, 8, 1'b1, 24, 9, 0, 0);
      idle(20, 24);
      check_eq("wr_wins", v1, 8);
      check_eq("pre_drop", v2, 0);

      step(1'b0, 1'b1, 510, 32'h1234_5678, 1'b0, 0, 0, 0, 0);
      check_eq("err510", 32'(addr_err), 1);
      idle(508, 0);
      check_eq("rd508", v1, 0);

      // Fresh sweep, then random traffic; out-of-range addresses only late in the run.
      step(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
      wait_ready();
      for (int i = 0; i < 400; i++) begin
         logic [31:0] wa, pa, ra1, ra2;
         bit          we, pe;
         we  = ($urandom_range(0, 2) == 0);
         pe  = ($urandom_range(0, 3) == 0);
         wa  = rnd_addr(i >= 300);
         pa  = rnd_addr(i >= 300);
         ra1 = ($urandom_range(0, 3) == 0) ? wa : rnd_addr(i >= 300);
         ra2 = ($urandom_range(0, 5) == 0) ? pa : rnd_addr(i >= 300);
         step(1'b0, we, wa, $urandom, pe, pa, $urandom, ra1, ra2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pc_reg_mem.md
# pc_reg_mem

Unified byte-addressed register/instruction store that answers the ID stage's register traffic. It serves the two read ports (`load_pc_reg_addr1/2` → `load_pc_reg_value1/2`) and the write-back port (`write_pc_reg_addr/value`), and adds a preload port for instructions. It sits beside ID in the 32-bit RISC-V pipeline and replaces the bench-side `data_reg` model with synthesizable RTL. Storage is big-endian: byte `a` holds bits [31:24] of the word at address `a`.

## Interface
Parameters:
- `MEM_BYTES`, 512, store size in bytes; multiple of 4, at least 8
- `CLR_PER_CYC`, 4, bytes zeroed per cycle during clear; divides `MEM_BYTES`

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `load_pc_reg_addr1`  in  32  read port 1 byte address (from ID)
- `load_pc_reg_addr2`  in  32  read port 2 byte address (from ID)
- `load_pc_reg_value1`  out  32  word at addr1 (to ID)
- `load_pc_reg_value2`  out  32  word at addr2 (to ID)
- `write_en`  in  1  write-back strobe
- `write_pc_reg_addr`  in  32  write byte address (from ID)
- `write_pc_reg_value`  in  32  write word (from ID)
- `pre_en`  in  1  preload strobe (instruction image)
- `pre_addr`  in  32  preload byte address
- `pre_data`  in  32  preload word
- `ready`  out  1  high when clear has finished and ports are serviced
- `addr_err`  out  1  sticky; set on any out-of-range access

## Operation
- States: CLEAR and RUN.
- Reset: enter CLEAR; clear pointer = 0; `ready`=0; `addr_err`=0.
- CLEAR: each cycle zero `CLR_PER_CYC` bytes starting at the pointer, then advance the pointer. Leave for RUN on the cycle the last group is written; the pointer wraps to 0. Reset asserted during CLEAR restarts the sweep from 0.
- During CLEAR: reads return 0; writes and preloads are dropped.
- RUN reads are combinational: `{m[a],m[a+1],m[a+2],m[a+3]}`.
- A read is out of range when `a+3 ≥ MEM_BYTES`. An out-of-range read returns 0, and `addr_err` sets at the next edge when the address is driven while `ready`=1.
- Bytes 0..3 (x0) are hard-wired: reads return 0 and writes to them are ignored, including partial overlap on bytes 0..3.
- RUN writes: when `write_en`=1 and the address is in range, all 4 bytes are stored at the edge. An out-of-range write is dropped and sets `addr_err`.
- Preload follows the same rules as a write. When `pre_en` and `write_en` are both high, the write-back wins and the preload is dropped.
- Bypass: when a read address equals an accepted write address in the same cycle, the read returns `write_pc_reg_value`. Overlapping but unequal addresses are not bypassed.
- Unaligned addresses are legal, because the byte array allows any offset.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge, with bypass covering the same cycle.
- After reset deasserts, CLEAR lasts `MEM_BYTES/CLR_PER_CYC` cycles (128 by default). `ready` rises the cycle after the last clear write.
- `addr_err` is cleared only by `reset`.
- Reset values: `load_pc_reg_value1/2` = 0 (CLEAR forces 0), `ready`=0, `addr_err`=0.

## Structure
- Shared package `pc_reg_pkg`:
  - state enum {CLEAR, RUN}
  - `WORD_W`=32
  - `X0_LIMIT`=4
- Sub-module `pc_reg_rdport`: combinational read with range check, x0 mask and bypass. It is instantiated twice.
- The top level holds the byte array, the clear FSM, and write/preload arbitration.

## Test plan
- Reset then idle:
  - `ready` stays 0 for 128 cycles, then 1.
  - Reading address 20 returns 0.
  - Reset pulsed at clear cycle 50 restarts the count, so `ready` rises 128 cycles after that reset.
- Preload `pre_addr`=400, `pre_data`=0x0070_0613:
  - a read at 400 returns 0x00700613
  - bytes 400..403 are 0x00, 0x70, 0x06, 0x13
- Write-back `write_pc_reg_addr`=12, value 15, with `load_pc_reg_addr1`=12 in the same cycle:
  - `load_pc_reg_value1`=15 combinationally
  - a read next cycle without the write still returns 15
- Write 0xDEADBEEF to address 0:
  - a read at 0 returns 0
  - `addr_err` stays 0
- Write to 510 (with 512 bytes):
  - the write is dropped and `addr_err`=1 next cycle
  - a read at 508 returns 0
- Simultaneous `write_en` to 20 (value 8) and `pre_en` to 24 (value 9):
  - the read at 20 returns 8
  - the read at 24 returns 0
